obstacle_bank: RTL

Parametrised bank of N_OBS circular obstacles for the bullet-box screen. Each obstacle bounces along its own axis at a frame-divided rate. Each one is retired when the player sprite overlaps it, and comes back on a respawn pulse. Sits between the VGA timing generator (xx/yy/aactive) and the pixel mux, alongside the player sprite; its hit pulse feeds the HP/score logic.

---
 rtl/vga_consts.sv | 11 +
 rtl/obstacle_channel.sv | 89 ++++++++
 rtl/obstacle_bank.sv | 99 +++++++++
 3 files changed

// File: rtl/vga_consts.sv
// VGA timing constants and axis encodings shared by the sprite blocks.
package vga_consts;
    localparam int COORD_W = 10;
    localparam logic [COORD_W-1:0] H_LAST = 10'd639;
    localparam logic [COORD_W-1:0] V_LAST = 10'd479;

    typedef enum logic {
        AXIS_VERT  = 1'b0,
        AXIS_HORIZ = 1'b1
    } axis_t;
endpackage

// File: rtl/obstacle_channel.sv
// One bouncing circular obstacle: position, direction and alive flag,
// plus the combinational "pixel inside circle" test.
module obstacle_channel
    import vga_consts::*;
#(
    parameter int                 RADIUS    = 9,
    parameter int                 STEP      = 6,
    parameter int                 POS_MIN   = 220,
    parameter int                 POS_MAX   = 380,
    parameter logic [COORD_W-1:0] INIT_X    = 10'd320,
    parameter logic [COORD_W-1:0] INIT_Y    = 10'd320,
    parameter logic               INIT_AXIS = 1'b0
) (
    input  logic               Pclk,
    input  logic               rst,
    input  logic               respawn,
    input  logic               update,
    input  logic               kill,
    input  logic [COORD_W-1:0] xx,
    input  logic [COORD_W-1:0] yy,
    output logic               circle,
    output logic               alive
);
    localparam logic [21:0] R_SQ = 22'(RADIUS * RADIUS);
    localparam axis_t       AXIS = axis_t'(INIT_AXIS);

    logic [COORD_W-1:0] cx_reg, cy_reg;
    logic               dir_reg, alive_reg;
    logic [COORD_W:0]   p_cur, p_next;
    logic               dir_next;

    // 11-bit arithmetic so p+STEP can never wrap before the bound check.
    always_comb begin
        p_cur    = (AXIS == AXIS_HORIZ) ? {1'b0, cx_reg} : {1'b0, cy_reg};
        p_next   = p_cur;
        dir_next = dir_reg;
        if (dir_reg) begin
            if (p_cur + 11'(STEP) >= 11'(POS_MAX)) begin
                p_next   = 11'(POS_MAX);
                dir_next = 1'b0;
            end else begin
                p_next = p_cur + 11'(STEP);
            end
        end else begin
            if (p_cur <= 11'(POS_MIN + STEP)) begin
                p_next   = 11'(POS_MIN);
                dir_next = 1'b1;
            end else begin
                p_next = p_cur - 11'(STEP);
            end
        end
    end

    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            cx_reg    <= INIT_X;
            cy_reg    <= INIT_Y;
            dir_reg   <= 1'b1;
            alive_reg <= 1'b1;
        end else if (respawn) begin
            cx_reg    <= INIT_X;
            cy_reg    <= INIT_Y;
            dir_reg   <= 1'b1;
            alive_reg <= 1'b1;
        end else begin
            if (update) begin
                if (AXIS == AXIS_HORIZ) cx_reg <= p_next[COORD_W-1:0];
                else                    cy_reg <= p_next[COORD_W-1:0];
                dir_reg <= dir_next;
            end
            if (kill) alive_reg <= 1'b0;
        end
    end

    logic signed [COORD_W:0] dx, dy;
    logic        [COORD_W:0] adx, ady;
    logic        [21:0]      dist_sq;

    always_comb begin
        dx      = $signed({1'b0, xx}) - $signed({1'b0, cx_reg});
        dy      = $signed({1'b0, yy}) - $signed({1'b0, cy_reg});
        adx     = dx[COORD_W] ? (~dx + 11'sd1) : dx;
        ady     = dy[COORD_W] ? (~dy + 11'sd1) : dy;
        dist_sq = 22'(adx) * 22'(adx) + 22'(ady) * 22'(ady);
        circle  = (dist_sq <= R_SQ);
    end

    assign alive = alive_reg;
endmodule

// File: rtl/obstacle_bank.sv
// Bank of N_OBS bouncing obstacles: frame-divided motion, pixel draw with
// lowest-index priority, and player collision that retires obstacles.
module obstacle_bank
    import vga_consts::*;
#(
    parameter int                         N_OBS     = 4,
    parameter int                         RADIUS    = 9,
    parameter int                         STEP      = 6,
    parameter int                         DIV       = 3,
    parameter int                         POS_MIN   = 220,
    parameter int                         POS_MAX   = 380,
    parameter logic [N_OBS*COORD_W-1:0]   INIT_X    = {10'd380, 10'd340, 10'd300, 10'd260},
    parameter logic [N_OBS*COORD_W-1:0]   INIT_Y    = {10'd260, 10'd300, 10'd240, 10'd300},
    parameter logic [N_OBS-1:0]           INIT_AXIS = 4'b0101,
    localparam int                        IDX_W     = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
    input  logic               Pclk,
    input  logic               rst,
    input  logic [COORD_W-1:0] xx,
    input  logic [COORD_W-1:0] yy,
    input  logic               aactive,
    input  logic               player_on,
    input  logic               blank,
    input  logic               respawn,
    output logic               ObstacleSpriteOn,
    output logic [IDX_W-1:0]   obstacle_idx,
    output logic               hit_pulse,
    output logic [N_OBS-1:0]   alive_mask
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] frame_cnt_reg;
    logic             frame_tick, update;
    logic [N_OBS-1:0] circle, alive, hit, kill;

    assign frame_tick = (xx == H_LAST) && (yy == V_LAST);
    assign update     = frame_tick && (frame_cnt_reg == CNT_W'(DIV - 1)) && !respawn;

    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (respawn) begin
            frame_cnt_reg <= '0;
        end else if (frame_tick) begin
            frame_cnt_reg <= update ? '0 : frame_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_OBS; gi++) begin : g_obs
            obstacle_channel #(
                .RADIUS   (RADIUS),
                .STEP     (STEP),
                .POS_MIN  (POS_MIN),
                .POS_MAX  (POS_MAX),
                .INIT_X   (INIT_X[gi*COORD_W +: COORD_W]),
                .INIT_Y   (INIT_Y[gi*COORD_W +: COORD_W]),
                .INIT_AXIS(INIT_AXIS[gi])
            ) u_channel (
                .Pclk   (Pclk),
                .rst    (rst),
                .respawn(respawn),
                .update (update),
                .kill   (kill[gi]),
                .xx     (xx),
                .yy     (yy),
                .circle (circle[gi]),
                .alive  (alive[gi])
            );
            assign hit[gi]  = alive[gi] && aactive && circle[gi];
            assign kill[gi] = hit[gi] && player_on && !blank;
        end
    endgenerate

    logic [IDX_W-1:0] idx_next;

    // Descending scan so the lowest covering index is the one left standing.
    always_comb begin
        idx_next = '0;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            if (hit[i]) idx_next = IDX_W'(i);
        end
    end

    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            ObstacleSpriteOn <= 1'b0;
            obstacle_idx     <= '0;
            hit_pulse        <= 1'b0;
        end else begin
            ObstacleSpriteOn <= !blank && (|hit);
            obstacle_idx     <= blank ? '0 : idx_next;
            hit_pulse        <= (|kill) && !respawn;
        end
    end

    assign alive_mask = alive;
endmodule
